instr_field_encoder: RTL

- Streaming RV32I instruction encoder.
- Accepts opcode, register, funct3 and immediate fields over a valid/ready handshake and scatters the immediate into the format-specific bit positions.
- Emits 32-bit instruction words tagged with a byte address through a 2-entry output buffer.
- Exact inverse of the core's immediate decoder; used by the boot-loader/program-builder path and as a round-trip checker in verification.

---
 rtl/rv_isa_pkg.sv | 33 +++
 rtl/imm_scatter.sv | 74 +++++++
 rtl/instr_field_encoder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/rv_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_isa_pkg
// Description : Shared RV32I encoding constants and the output-buffer entry
//               type used by the instruction field encoder.
// Contents    : OP_* major opcodes, NOP_INSTR canonical no-op word,
//               ADDR_W buffer address field width, entry_t buffer entry.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_isa_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0, x0, 0 -- substituted for any entry that cannot be encoded
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Address field width carried in a buffer entry; the encoder's AddrW
    // parameter is expected not to exceed this.
    localparam int ADDR_W = 32;

    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] addr;
        logic              err;
    } entry_t;

endpackage : rv_isa_pkg
`default_nettype wire

// File: rtl/imm_scatter.sv
`default_nettype none
// ============================================================================
// Module      : imm_scatter
// Description : Combinational RV32I field packer. Scatters a signed
//               immediate into the format-specific bit positions and flags
//               out-of-range immediates or unsupported opcodes.
// Ports       : opcode/rd/rs1/rs2/funct3/imm in -> instr (32b), err out.
//               On err, instr is the canonical NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_scatter
    import rv_isa_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [Width-1:0] imm,
    output logic [31:0]      instr,
    output logic             err
);

    // Sign-extension bits above the encodable field must all match the
    // field's own sign bit, so they are checked together with it.
    logic [Width-12:0] w_ext12;
    logic [Width-20:0] w_ext20;
    logic              w_fit12;
    logic              w_fit20;
    logic [31:0]       w_raw;
    logic              w_bad;

    assign w_ext12 = imm[Width-1:11];
    assign w_ext20 = imm[Width-1:19];
    assign w_fit12 = (&w_ext12) | ~(|w_ext12);
    assign w_fit20 = (&w_ext20) | ~(|w_ext20);

    always_comb begin
        w_raw = 32'h0;
        w_bad = 1'b1;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: begin
                w_raw = {imm[11:0], rs1, funct3, rd, opcode};
                w_bad = ~w_fit12;
            end
            OP_STORE: begin
                w_raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                w_bad = ~w_fit12;
            end
            OP_BRANCH: begin
                // imm holds a halfword offset: imm[11:0] is byte offset [12:1]
                w_raw = {imm[11], imm[9:4], rs2, rs1, funct3,
                         imm[3:0], imm[10], opcode};
                w_bad = ~w_fit12;
            end
            OP_JAL: begin
                // imm holds a halfword offset: imm[19:0] is byte offset [20:1]
                w_raw = {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode};
                w_bad = ~w_fit20;
            end
            default: begin
                w_raw = 32'h0;
                w_bad = 1'b1;
            end
        endcase
    end

    assign instr = w_bad ? NOP_INSTR : w_raw;
    assign err   = w_bad;

endmodule : imm_scatter
`default_nettype wire

// File: rtl/instr_field_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_field_encoder
// Description : Streaming RV32I instruction encoder. Accepted requests are
//               encoded combinationally, tagged with a running byte address
//               and held in a 2-entry in-order output buffer.
// Ports       : in_*        request fields, valid/ready handshake
//               addr_load / load_addr   reload of the address counter
//               out_*       buffer head (instr, addr, err), valid/ready
//               err_sticky / err_clr    accumulated error flag and clear
// Revision    : 1.0 - initial release
// ============================================================================
module instr_field_encoder
    import rv_isa_pkg::*;
#(
    parameter int Width = 32,
    parameter int AddrW = ADDR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [Width-1:0] in_imm,
    input  logic             addr_load,
    input  logic [AddrW-1:0] load_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [AddrW-1:0] out_addr,
    output logic             out_err,
    output logic             err_sticky,
    input  logic             err_clr
);

    entry_t             slot0_q, slot0_d;   // head of buffer
    entry_t             slot1_q, slot1_d;   // second entry
    logic [1:0]         count_q, count_d;
    logic [AddrW-1:0]   counter_q, counter_d;
    logic               err_sticky_q, err_sticky_d;

    logic [31:0]        w_enc_instr;
    logic               w_enc_err;
    logic               w_push;
    logic               w_pop;
    logic [AddrW-1:0]   w_tag;
    entry_t             w_new;

    imm_scatter #(
        .Width (Width)
    ) u_imm_scatter (
        .opcode (in_opcode),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .imm    (in_imm),
        .instr  (w_enc_instr),
        .err    (w_enc_err)
    );

    // Ready depends only on registered occupancy, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready = (count_q != 2'd2);
    assign w_push   = in_valid & in_ready;
    assign w_pop    = out_valid & out_ready;

    // A load in the push cycle tags that very entry with load_addr.
    assign w_tag = addr_load ? load_addr : counter_q;

    always_comb begin
        w_new.instr = w_enc_instr;
        w_new.addr  = ADDR_W'(w_tag);
        w_new.err   = w_enc_err;

        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;

        case ({w_push, w_pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    slot0_d = w_new;
                end else begin
                    slot1_d = w_new;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Push is only possible at count 0/1 and pop needs count>=1,
                // so this is count==1: the new entry replaces the departing head.
                slot0_d = w_new;
            end
            default: ;
        endcase

        counter_d = counter_q;
        if (w_push) begin
            counter_d = w_tag + AddrW'(4);
        end else if (addr_load) begin
            counter_d = load_addr;
        end

        // A new error outranks a simultaneous clear.
        err_sticky_d = err_sticky_q;
        if (w_push && w_enc_err) begin
            err_sticky_d = 1'b1;
        end else if (err_clr) begin
            err_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q      <= '0;
            slot1_q      <= '0;
            count_q      <= 2'd0;
            counter_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            slot0_q      <= slot0_d;
            slot1_q      <= slot1_d;
            count_q      <= count_d;
            counter_q    <= counter_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign out_valid  = (count_q != 2'd0);
    assign out_instr  = slot0_q.instr;
    assign out_addr   = AddrW'(slot0_q.addr);
    assign out_err    = slot0_q.err;
    assign err_sticky = err_sticky_q;

endmodule : instr_field_encoder
`default_nettype wire
